bitonic_sort_ctrl: RTL and testbench

Sequencer for the iterative bitonic sorter in the bitonic_mesh design. The sorter uses one compare-exchange network, whose outputs feed a bank of enable-gated data registers. This block handles the load/unload handshakes and drives the register enables. It steps the network through every (k, j) stage pair of a 2^LOG_N-element bitonic sort, holding each step for STEP_LAT cycles to cover the network's combinational/pipeline latency.

---
 rtl/bitonic_ctrl_pkg.sv | 29 ++
 rtl/bitonic_kj_gen.sv | 61 ++++++
 rtl/bitonic_sort_ctrl.sv | 93 +++++++++
 tb/tb_bitonic_sort_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitonic_ctrl_pkg.sv
// Shared types and width helpers for the bitonic sorter sequencer.
// The helpers are constant functions, so parameter lists can call them.
package bitonic_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of (k, j) compare-exchange steps in a 2^log_n element sort.
  function automatic int nsteps(input int log_n);
    return log_n * (log_n + 1) / 2;
  endfunction

  function automatic int kw(input int log_n);
    return $clog2(log_n + 1);
  endfunction

  function automatic int sw(input int log_n);
    return $clog2(nsteps(log_n) + 1);
  endfunction

  // Width of the per-step latency counter. It is never zero, so STEP_LAT=1 still gets one bit.
  function automatic int lw(input int step_lat);
    return (step_lat > 1) ? $clog2(step_lat) : 1;
  endfunction

endpackage

// File: rtl/bitonic_kj_gen.sv
// Walks the (k, j) stage pairs of the bitonic network.
// Each step is held for STEP_LAT cycles, and step_en marks the last cycle of the step.
module bitonic_kj_gen
  import bitonic_ctrl_pkg::*;
#(
  parameter  int LOG_N    = 3,
  parameter  int STEP_LAT = 1,
  localparam int KW       = kw(LOG_N),
  localparam int SW       = sw(LOG_N),
  localparam int LW       = lw(STEP_LAT)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          run,
  input  logic          restore,
  input  logic          flush,
  output logic          step_en,
  output logic          last_step,
  output logic [KW-1:0] k_idx,
  output logic [KW-1:0] j_idx,
  output logic [SW-1:0] step_cnt
);

  logic [LW-1:0] lat_cnt;

  assign step_en   = run && (lat_cnt == LW'(STEP_LAT - 1));
  assign last_step = (j_idx == '0) && (k_idx == KW'(LOG_N));

  // NOTE: sequential state uses non-blocking assignments only. Every register then
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      lat_cnt  <= '0;
      k_idx    <= KW'(1);
      j_idx    <= '0;
      step_cnt <= '0;
    end else if (start) begin
      lat_cnt  <= '0;
      k_idx    <= KW'(1);
      j_idx    <= '0;
      step_cnt <= '0;
    end else if (restore) begin
      // step_cnt is kept so the sink can still read it after unload.
      k_idx <= KW'(1);
      j_idx <= '0;
    end else if (step_en) begin
      lat_cnt  <= '0;
      step_cnt <= step_cnt + SW'(1);
      if (j_idx != '0) begin
        j_idx <= j_idx - KW'(1);
      end else if (!last_step) begin
        k_idx <= k_idx + KW'(1);
        j_idx <= k_idx;
      end
    end else if (run) begin
      lat_cnt <= lat_cnt + LW'(1);
    end
  end

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Load/sort/unload sequencer for the iterative bitonic sorter.
// It drives the data-register enables and the (k, j) stage indices used by the network.
module bitonic_sort_ctrl
  import bitonic_ctrl_pkg::*;
#(
  parameter  int LOG_N    = 3,
  parameter  int STEP_LAT = 1,
  localparam int KW       = kw(LOG_N),
  localparam int SW       = sw(LOG_N)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          load_en,
  output logic          step_en,
  output logic [KW-1:0] k_idx,
  output logic [KW-1:0] j_idx,
  output logic [SW-1:0] step_cnt,
  output logic          busy
);

  state_t state, state_nxt;
  logic   gen_step, last_step;

  bitonic_kj_gen #(
    .LOG_N   (LOG_N),
    .STEP_LAT(STEP_LAT)
  ) u_kj_gen (
    .clk      (clk),
    .resetn   (resetn),
    .start    (load_en),
    .run      (state == ST_SORT),
    .restore  (out_valid && out_ready),
    .flush    (flush),
    .step_en  (gen_step),
    .last_step(last_step),
    .k_idx    (k_idx),
    .j_idx    (j_idx),
    .step_cnt (step_cnt)
  );

  // NOTE: the reset is synchronous, so it is sampled here, inside the clocked block.
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: each signal gets a default at the top of the block. Otherwise a branch
  // that leaves it unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (load_en) state_nxt = ST_SORT;
        ST_SORT: if (step_en && last_step) state_nxt = ST_DONE;
        ST_DONE: if (out_valid && out_ready) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    step_en   = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_SORT: begin
        busy    = 1'b1;
        step_en = gen_step && !flush;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: in_ready = !flush;  // the unused encoding behaves as IDLE
    endcase
    if (!resetn) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      step_en   = 1'b0;
      busy      = 1'b0;
    end
    load_en = in_ready && in_valid;
  end

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Bench for bitonic_sort_ctrl: three parameterisations share one directed input stream.
// A cycle-count model checks every output on every cycle, and literal checks pin the model.
module tb_bitonic_sort_ctrl;

  logic clk = 1'b0;
  logic resetn, flush, in_valid, out_ready;

  logic       in_ready0, out_valid0, load_en0, step_en0, busy0;
  logic [1:0] k0, j0;
  logic [2:0] s0;
  logic       in_ready1, out_valid1, load_en1, step_en1, busy1;
  logic [1:0] k1, j1;
  logic [2:0] s1;
  logic       in_ready2, out_valid2, load_en2, step_en2, busy2;
  logic [0:0] k2, j2;
  logic [0:0] s2;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  bitonic_sort_ctrl #(.LOG_N(3), .STEP_LAT(1)) dut0 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_ready(out_ready), .load_en(load_en0), .step_en(step_en0),
    .k_idx(k0), .j_idx(j0), .step_cnt(s0), .busy(busy0));

  bitonic_sort_ctrl #(.LOG_N(3), .STEP_LAT(2)) dut1 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(out_ready), .load_en(load_en1), .step_en(step_en1),
    .k_idx(k1), .j_idx(j1), .step_cnt(s1), .busy(busy1));

  bitonic_sort_ctrl #(.LOG_N(1), .STEP_LAT(3)) dut2 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready), .load_en(load_en2), .step_en(step_en2),
    .k_idx(k2), .j_idx(j2), .step_cnt(s2), .busy(busy2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: each instance is idle, sorting (t cycles since accept) or done.
  int lg[3]  = '{3, 3, 1};
  int lat[3] = '{1, 2, 3};
  int pk[3][6], pj[3][6];
  int ms[3], mt[3], mc[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      int s;
      s = 0;
      for (int k = 1; k <= lg[i]; k++)
        for (int j = k - 1; j >= 0; j--) begin
          pk[i][s] = k;
          pj[i][s] = j;
          s++;
        end
      ms[i] = 0; mt[i] = 0; mc[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int ns;
      ns = lg[i] * (lg[i] + 1) / 2;
      if (!resetn || flush) begin
        ms[i] = 0; mt[i] = 0; mc[i] = 0;
      end else if (ms[i] == 0) begin
        if (in_valid) begin ms[i] = 1; mt[i] = 0; mc[i] = 0; end
      end else if (ms[i] == 1) begin
        if ((mt[i] % lat[i] == lat[i] - 1) && (mt[i] / lat[i] == ns - 1)) ms[i] = 2;
        else mt[i]++;
      end else if (out_ready) begin
        ms[i] = 0; mc[i] = ns;
      end
    end
  end

  logic [7:0] a_rdy[3], a_ov[3], a_ld[3], a_st[3], a_bz[3], a_k[3], a_j[3], a_c[3];
  always_comb begin
    a_rdy = '{8'(in_ready0), 8'(in_ready1), 8'(in_ready2)};
    a_ov  = '{8'(out_valid0), 8'(out_valid1), 8'(out_valid2)};
    a_ld  = '{8'(load_en0), 8'(load_en1), 8'(load_en2)};
    a_st  = '{8'(step_en0), 8'(step_en1), 8'(step_en2)};
    a_bz  = '{8'(busy0), 8'(busy1), 8'(busy2)};
    a_k   = '{8'(k0), 8'(k1), 8'(k2)};
    a_j   = '{8'(j0), 8'(j1), 8'(j2)};
    a_c   = '{8'(s0), 8'(s1), 8'(s2)};
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        int ns, st, ek, ej, ec;
        logic ok_run, e_rdy;
        ns     = lg[i] * (lg[i] + 1) / 2;
        st     = ms[i];
        ok_run = resetn && !flush;
        e_rdy  = ok_run && st == 0;
        if (st == 1) begin
          ek = pk[i][mt[i] / lat[i]]; ej = pj[i][mt[i] / lat[i]]; ec = mt[i] / lat[i];
        end else if (st == 2) begin
          ek = pk[i][ns - 1]; ej = pj[i][ns - 1]; ec = ns;
        end else begin
          ek = 1; ej = 0; ec = mc[i];
        end
        check($sformatf("inst%0d in_ready", i), a_rdy[i], e_rdy);
        check($sformatf("inst%0d load_en", i), a_ld[i], e_rdy && in_valid);
        check($sformatf("inst%0d step_en", i), a_st[i],
              ok_run && st == 1 && (mt[i] % lat[i] == lat[i] - 1));
        check($sformatf("inst%0d out_valid", i), a_ov[i], resetn && st == 2);
        check($sformatf("inst%0d busy", i), a_bz[i], resetn && st != 0);
        check($sformatf("inst%0d k_idx", i), a_k[i], ek);
        check($sformatf("inst%0d j_idx", i), a_j[i], ej);
        check($sformatf("inst%0d step_cnt", i), a_c[i], ec);
      end
    end
  end

  int lk[6] = '{1, 2, 2, 3, 3, 3};
  int lj[6] = '{0, 1, 0, 2, 1, 0};

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("reset in_ready forced low", in_ready0, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_en = 1'b1;
    check("reset in_ready", in_ready0, 1);
    check("reset k", k0, 1);
    check("reset j", j0, 0);
    check("reset step_cnt", s0, 0);
    check("reset busy", busy0, 0);

    for (int c = 0; c < 56; c++) begin
      @(posedge clk);
      #1;
      in_valid  = (c == 0) || (c >= 14 && c <= 17) || c == 19 || c == 23 || c == 25 ||
                  c == 28 || (c >= 30 && c < 50);
      out_ready = (c == 18) || (c >= 30 && c < 50);
      flush     = (c == 23);
      resetn    = (c != 28);
      @(negedge clk);
      // Plain sort: one step per cycle for instance 0, one step per two cycles for instance 1.
      if (c == 0) begin
        check("t1 load_en", load_en0, 1);
        check("t2 load_en", load_en1, 1);
        check("t6 load_en", load_en2, 1);
      end
      if (c >= 1 && c <= 6) begin
        check("t1 step_en", step_en0, 1);
        check("t1 k", k0, lk[c-1]);
        check("t1 j", j0, lj[c-1]);
      end
      if (c == 7) begin
        check("t1 out_valid", out_valid0, 1);
        check("t1 step_cnt", s0, 6);
        check("t1 step_en done", step_en0, 0);
      end
      if (c >= 1 && c <= 13) check("t2 step_en", step_en1, (c % 2 == 0) && c <= 12);
      if (c >= 1 && c <= 12) begin
        check("t2 k", k1, lk[(c-1)/2]);
        check("t2 j", j1, lj[(c-1)/2]);
      end
      if (c == 12) check("t2 out_valid early", out_valid1, 0);
      if (c == 13) begin
        check("t2 out_valid", out_valid1, 1);
        check("t2 step_cnt", s1, 6);
      end
      if (c == 3) check("lg1 step_en", step_en2, 1);
      if (c == 4) begin
        check("lg1 out_valid", out_valid2, 1);
        check("lg1 step_cnt", s2, 1);
      end
      // Backpressure in DONE; in_valid is asserted on cycles 14..17 and must be ignored.
      if (c >= 13 && c <= 17) begin
        check("t3 out_valid held", out_valid1, 1);
        check("t3 in_ready", in_ready1, 0);
        check("t3 load_en", load_en1, 0);
        check("t3 step_en", step_en1, 0);
      end
      if (c == 19) begin
        check("t3 in_ready after unload", in_ready1, 1);
        check("t3 out_valid cleared", out_valid1, 0);
        check("t3 step_cnt kept", s0, 6);
        check("t3 k restored", k0, 1);
      end
      // Flush after the third step, with in_valid asserted in the same cycle.
      if (c == 22) begin
        check("t4 third step", step_en0, 1);
        check("t4 third k", k0, 2);
      end
      if (c == 23) begin
        check("t4 flush load_en", load_en0, 0);
        check("t4 flush step_en", step_en0, 0);
        check("t4 flush in_ready", in_ready0, 0);
      end
      if (c == 24) begin
        check("t4 idle in_ready", in_ready0, 1);
        check("t4 k", k0, 1);
        check("t4 j", j0, 0);
        check("t4 step_cnt", s0, 0);
        check("t4 busy", busy0, 0);
      end
      if (c == 25) check("t4 reaccept", load_en0, 1);
      if (c == 26) check("t4 first step", step_en0, 1);
      // Reset mid-sort, with in_valid asserted in the same cycle.
      if (c == 28) begin
        check("t5 load_en", load_en0, 0);
        check("t5 step_en", step_en0, 0);
        check("t5 in_ready", in_ready0, 0);
        check("t5 busy", busy0, 0);
      end
      if (c == 29) begin
        check("t5 in_ready after", in_ready0, 1);
        check("t5 busy after", busy0, 0);
        check("t5 k after", k0, 1);
        check("t5 step_cnt after", s0, 0);
      end
      // Back-to-back sorts for LOG_N=1 with out_ready held high.
      if (c >= 30 && c < 50) begin
        check("t6 load_en", load_en2, (c - 30) % 5 == 0);
        check("t6 step_en", step_en2, (c - 30) % 5 == 3);
        check("t6 out_valid", out_valid2, (c - 30) % 5 == 4);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
